// File: rtl/audio_stream_ctrl.sv
// Audio codec stream controller: captures ADC pairs into a FIFO and
// plays them back to the DAC through a 3-cycle-minimum handshake FSM.
module audio_stream_ctrl #(
    parameter int DEPTH = 8,
    parameter int PRIME = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mute,
    input  logic                     read_ready,
    input  logic                     write_ready,
    input  logic [23:0]              readdata_left,
    input  logic [23:0]              readdata_right,
    output logic                     read,
    output logic                     write,
    output logic [23:0]              writedata_left,
    output logic [23:0]              writedata_right,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [7:0]               overflow_cnt,
    output logic [7:0]               underflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_LVL = (AW+1)'(PRIME);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    state_t        state;
    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          primed;
    logic          live;
    logic          push;
    logic          go_rd;
    logic          go_wr;

    // The pair is stored at the edge that ends the RD cycle, so a reset
    // landing on that edge discards it.
    assign push  = (state == RD) && (fill != FULL);
    assign go_rd = read_ready && ((fill != FULL) || !write_ready);
    assign go_wr = write_ready && primed;

    always_ff @(posedge CLOCK_50) begin
        if (push && !reset) begin
            mem[wptr] <= {readdata_left, readdata_right};
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state           <= IDLE;
            read            <= 1'b0;
            write           <= 1'b0;
            writedata_left  <= '0;
            writedata_right <= '0;
            fill            <= '0;
            wptr            <= '0;
            rptr            <= '0;
            primed          <= 1'b0;
            live            <= 1'b0;
            overflow_cnt    <= '0;
            underflow_cnt   <= '0;
        end else begin
            live  <= 1'b1;
            read  <= 1'b0;
            write <= 1'b0;

            if (!enable) begin
                primed <= 1'b0;
            end else if (fill >= PRIME_LVL) begin
                primed <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    // live holds off the first decision one extra cycle
                    if (enable && live) begin
                        if (go_rd) begin
                            state <= RD;
                            read  <= 1'b1;
                        end else if (go_wr) begin
                            state <= WR;
                            write <= 1'b1;
                            if (fill != '0) begin
                                writedata_left  <= mute ? 24'd0 : mem[rptr][47:24];
                                writedata_right <= mute ? 24'd0 : mem[rptr][23:0];
                                rptr            <= rptr + 1'b1;
                                fill            <= fill - 1'b1;
                            end else begin
                                writedata_left  <= '0;
                                writedata_right <= '0;
                                if (underflow_cnt != 8'hFF) begin
                                    underflow_cnt <= underflow_cnt + 8'd1;
                                end
                            end
                        end
                    end
                end
                RD: begin
                    state <= GAP;
                    if (push) begin
                        wptr <= wptr + 1'b1;
                        fill <= fill + 1'b1;
                    end else if (overflow_cnt != 8'hFF) begin
                        overflow_cnt <= overflow_cnt + 8'd1;
                    end
                end
                WR: begin
                    state <= GAP;
                end
                GAP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/audio_stream_ctrl.md
AUDIO_STREAM_CTRL -- requirements
Module: audio_stream_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO depth in stereo sample pairs; power of two, 2..64.
REQ-002 SHALL have parameter PRIME, default 4: FIFO fill level needed before playback starts; 1..DEPTH.
REQ-003 SHALL have port CLOCK_50, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: permits new codec transactions.
REQ-006 SHALL have port mute, input, 1: forces DAC data to zero.
REQ-007 SHALL have port read_ready, input, 1: codec ADC sample pair available.
REQ-008 SHALL have port write_ready, input, 1: codec DAC can accept a pair.
REQ-009 SHALL have ports readdata_left and readdata_right, input, 24 each: ADC samples.
REQ-010 SHALL have port read, output, 1: one-cycle pop strobe to the codec.
REQ-011 SHALL have port write, output, 1: one-cycle push strobe to the codec.
REQ-012 SHALL have ports writedata_left and writedata_right, output, 24 each: DAC samples.
REQ-013 SHALL have port fill, output, log2(DEPTH)+1: current FIFO occupancy.
REQ-014 SHALL have port overflow_cnt, output, 8: dropped-sample counter, saturating.
REQ-015 SHALL have port underflow_cnt, output, 8: starved-write counter, saturating.

Function
REQ-016 SHALL implement FSM states IDLE, RD, WR, GAP; all outputs registered.
REQ-017 SHALL decide in IDLE, with enable=1: if read_ready=1 and (fill<DEPTH or write_ready=0), go RD; else if write_ready=1 and primed=1, go WR; else stay IDLE. Read has priority.
REQ-018 SHALL, in RD, assert read=1 for exactly one cycle; if fill<DEPTH, push {readdata_left,readdata_right} sampled that cycle, else drop the pair and increment overflow_cnt.
REQ-019 SHALL, in WR, assert write=1 for exactly one cycle; if fill>0, drive the FIFO head (or 0 when mute=1) and pop; else drive 0 and increment underflow_cnt.
REQ-020 SHALL hold writedata_left/right stable from the WR cycle until the next WR cycle.
REQ-021 SHALL go from RD or WR to GAP, and from GAP to IDLE unconditionally, so that each codec transaction takes 3 cycles min. This lets the ready flags settle.
REQ-022 SHALL set primed when fill reaches PRIME and clear it on reset or enable=0; primed is not cleared by underflow.
REQ-023 SHALL, on enable deassert mid-transaction, complete RD/WR and GAP, then stay in IDLE; FIFO contents are retained.
REQ-024 SHALL apply mute on the WR cycle only; the FIFO pops normally while muted.
REQ-025 SHALL wrap FIFO read/write pointers modulo DEPTH; fill SHALL never exceed DEPTH or go below 0.
REQ-026 SHALL saturate both counters at 255, with no wrap.
REQ-027 SHALL keep read and write never high in the same cycle.

Reset
REQ-028 SHALL, while reset=1, force state=IDLE, read=0, write=0, writedata=0, fill=0, pointers=0, primed=0, counters=0.
REQ-029 SHALL let reset take effect on the next edge from any state, including RD/WR; an in-flight push/pop SHALL be discarded.
REQ-030 SHALL issue the first strobe no earlier than 2 cycles after reset deasserts.

Verification
REQ-031 SHALL cover basic capture: enable=1, read_ready pulsed 4 times with L=24'h000001..4, R=~L, write_ready=0 -> 4 read pulses 3+ cycles apart, fill=4, primed=1.
REQ-032 SHALL cover playback order: after REQ-031, write_ready=1 and read_ready=0 -> 4 write pulses with L=1,2,3,4 in order, fill=0, underflow_cnt=0.
REQ-033 SHALL cover overflow: DEPTH=8, 10 reads and no writes -> fill=8, overflow_cnt=2, and FIFO contents are the first 8 pairs.
REQ-034 SHALL cover underflow and mute: primed, FIFO empty, write_ready=1 -> writedata=0, underflow_cnt increments per WR; mute=1 with fill=3 -> 3 writes of 0, fill=0.
REQ-035 SHALL cover simultaneous readiness: read_ready=write_ready=1 with fill=8 -> WR first, then RD; with fill<8 -> RD first.
REQ-036 SHALL cover reset mid-op: assert reset in the RD cycle -> next cycle read=0, fill=0, counters=0, and that sample is not stored.
